// File: rtl/mvb_pkg.sv
// Shared constants and types for the MVB receive path: delimiter patterns,
// check-sequence polynomial, framing sizes and the decoder state encoding.
package mvb_pkg;

  // Time order is MSB first; 1 = line high for that half-bit.
  localparam logic [17:0] MSD = 18'b10_11_00_01_11_00_01_01_01;
  localparam logic [17:0] SSD = 18'b10_10_10_00_11_10_00_11_10;

  // x^7 + x^6 + x^5 + x^2 + 1, x^7 implicit
  localparam logic [6:0] CRC_POLY = 7'h65;

  localparam int QUIET_HB    = 4;
  localparam int GROUP_WORDS = 4;

  typedef enum logic [2:0] {
    QUIET,
    IDLE,
    DELIM,
    DATA,
    CHECK,
    END
  } rx_state_e;

  function automatic logic legal_len(input logic [4:0] n);
    return n inside {5'd1, 5'd2, 5'd4, 5'd8, 5'd16};
  endfunction

endpackage

// File: rtl/mvb_decode_if.sv
// Line and result bus of the MVB frame decoder.
interface mvb_decode_if;
  logic        line_in;
  logic [4:0]  exp_words;
  logic        frame_start;
  logic        frame_type;
  logic [15:0] word_out;
  logic        word_valid;
  logic [4:0]  word_count;
  logic        frame_over;
  logic        crc_err;
  logic        code_err;
  logic        reply_timeout;

  modport master (
    input  line_in, exp_words,
    output frame_start, frame_type, word_out, word_valid, word_count,
           frame_over, crc_err, code_err, reply_timeout
  );

  modport slave (
    output line_in, exp_words,
    input  frame_start, frame_type, word_out, word_valid, word_count,
           frame_over, crc_err, code_err, reply_timeout
  );
endinterface

// File: rtl/mvb_rx_crc.sv
// Serial CRC7 + even-parity checker; the receive twin of the frame encoder's
// check-sequence generator. err includes the bit being shifted this cycle.
module mvb_rx_crc
  import mvb_pkg::*;
(
  input  logic clk_24M,
  input  logic rst,
  input  logic clr,
  input  logic shift_d,
  input  logic shift_c,
  input  logic bit_in,
  output logic err
);

  logic [6:0] crc;
  logic [6:0] crc_nxt;
  logic [2:0] idx;
  logic       par;
  logic       err_q;
  logic       fb;
  logic       bad;

  // Check bits 0..6 are the CRC MSB first, bit 7 is the parity over data + CRC.
  always_comb begin
    fb      = bit_in ^ crc[6];
    crc_nxt = {crc[5:0], 1'b0} ^ (fb ? CRC_POLY : 7'h00);
    bad     = (idx == 3'd7) ? (bit_in ^ par) : (bit_in ^ crc[6]);
    err     = err_q | (shift_c & bad);
  end

  always_ff @(posedge clk_24M or negedge rst) begin
    if (!rst) begin
      crc   <= '0;
      idx   <= '0;
      par   <= 1'b0;
      err_q <= 1'b0;
    end else if (clr) begin
      crc   <= '0;
      idx   <= '0;
      par   <= 1'b0;
      err_q <= 1'b0;
    end else if (shift_d) begin
      crc <= crc_nxt;
      par <= par ^ bit_in;
    end else if (shift_c) begin
      err_q <= err;
      idx   <= idx + 1'b1;
      if (idx != 3'd7) begin
        crc <= {crc[5:0], 1'b0};
        par <= par ^ crc[6];
      end
    end
  end

endmodule

// File: rtl/mvb_decode.sv
// MVB Manchester receiver: delimiter detection, word decode, CRC7+parity check.
// Define MVB_RX_TIMEOUT_EN to build the reply watchdog behind reply_timeout.
module mvb_decode
  import mvb_pkg::*;
#(
  parameter int HALF_CYC    = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic          clk_24M,
  input  logic          rst,
  mvb_decode_if.master  bus
);

  localparam int HB_W = $clog2(HALF_CYC);
  localparam int QLEN = QUIET_HB * HALF_CYC;
  localparam int Q_W  = $clog2(QLEN + 1);
  localparam logic [HB_W-1:0] HB_MID  = HB_W'(HALF_CYC / 2);
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HALF_CYC - 1);

  rx_state_e state, state_nxt;

  logic [1:0]      sync;
  logic            s, s_d, edge_det, rise;
  logic [HB_W-1:0] hb_cnt;
  logic [Q_W-1:0]  quiet_cnt;
  logic            sample, quiet;

  logic [4:0]  hb_idx;
  logic [16:0] dsr;
  logic [17:0] dlm;
  logic        half_ph, first_half, pair_bad;
  logic [3:0]  bit_cnt;
  logic [1:0]  grp_cnt;
  logic [4:0]  exp_cnt;
  logic [14:0] word_sr;

  logic go_start, slave_hit, abort, word_done, chk_done, over;
  logic crc_clr, sh_d, sh_c, crc_e;

  logic        frame_start_q, frame_type_q, word_valid_q, frame_over_q;
  logic        crc_err_q, code_err_q;
  logic [15:0] word_out_q;
  logic [4:0]  word_count_q;

  assign s        = sync[1];
  assign edge_det = s ^ s_d;
  assign rise     = s & ~s_d;
  assign sample   = (hb_cnt == HB_MID);
  assign quiet    = (quiet_cnt == Q_W'(QLEN));

  mvb_rx_crc u_crc (
    .clk_24M (clk_24M),
    .rst     (rst),
    .clr     (crc_clr),
    .shift_d (sh_d),
    .shift_c (sh_c),
    .bit_in  (first_half),
    .err     (crc_e)
  );

  always_ff @(posedge clk_24M or negedge rst) begin
    if (!rst) state <= QUIET;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    go_start  = 1'b0;
    slave_hit = 1'b0;
    abort     = 1'b0;
    word_done = 1'b0;
    chk_done  = 1'b0;
    over      = 1'b0;
    crc_clr   = 1'b0;
    sh_d      = 1'b0;
    sh_c      = 1'b0;
    dlm       = {dsr, s};
    pair_bad  = (first_half == s);
    case (state)
      QUIET: if (quiet) state_nxt = IDLE;
      IDLE:  if (rise)  state_nxt = DELIM;
      DELIM: begin
        if (quiet) abort = 1'b1;
        else if (sample && hb_idx == 5'd17) begin
          if (dlm == MSD) go_start = 1'b1;
          else if (dlm == SSD && legal_len(bus.exp_words)) begin
            go_start  = 1'b1;
            slave_hit = 1'b1;
          end else abort = 1'b1;
        end
      end
      DATA: begin
        if (quiet) abort = 1'b1;
        else if (sample && half_ph) begin
          if (pair_bad) abort = 1'b1;
          else begin
            sh_d = 1'b1;
            if (bit_cnt == 4'd15) begin
              word_done = 1'b1;
              if (grp_cnt == 2'(GROUP_WORDS - 1) || 5'(word_count_q + 5'd1) == exp_cnt)
                state_nxt = CHECK;
            end
          end
        end
      end
      CHECK: begin
        if (quiet) abort = 1'b1;
        else if (sample && half_ph) begin
          if (pair_bad) abort = 1'b1;
          else begin
            sh_c = 1'b1;
            if (bit_cnt == 4'd7) begin
              chk_done = 1'b1;
              if (word_count_q == exp_cnt) state_nxt = END;
              else begin
                state_nxt = DATA;
                crc_clr   = 1'b1;
              end
            end
          end
        end
      end
      END: begin
        // Idle is low, so a high half-bit here means the sender kept talking.
        if (sample && s) abort = 1'b1;
        else if (quiet) begin
          over      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = QUIET;
    endcase
    if (go_start) begin
      state_nxt = DATA;
      crc_clr   = 1'b1;
    end
    if (abort) state_nxt = QUIET;
  end

  always_ff @(posedge clk_24M or negedge rst) begin
    if (!rst) begin
      sync          <= '0;
      s_d           <= 1'b0;
      hb_cnt        <= '0;
      quiet_cnt     <= '0;
      hb_idx        <= '0;
      dsr           <= '0;
      half_ph       <= 1'b0;
      first_half    <= 1'b0;
      bit_cnt       <= '0;
      grp_cnt       <= '0;
      exp_cnt       <= '0;
      word_sr       <= '0;
      frame_start_q <= 1'b0;
      frame_type_q  <= 1'b0;
      word_valid_q  <= 1'b0;
      frame_over_q  <= 1'b0;
      crc_err_q     <= 1'b0;
      code_err_q    <= 1'b0;
      word_out_q    <= '0;
      word_count_q  <= '0;
    end else begin
      sync <= {sync[0], bus.line_in};
      s_d  <= s;
      // Every edge realigns the half-bit phase and restarts the quiet timer.
      if (edge_det) begin
        hb_cnt    <= '0;
        quiet_cnt <= '0;
      end else begin
        hb_cnt <= (hb_cnt == HB_LAST) ? '0 : hb_cnt + 1'b1;
        if (!quiet) quiet_cnt <= quiet_cnt + 1'b1;
      end

      frame_start_q <= go_start;
      word_valid_q  <= word_done;
      frame_over_q  <= over;
      code_err_q    <= abort;

      if (state == IDLE) hb_idx <= '0;
      else if (state == DELIM && sample) begin
        hb_idx <= hb_idx + 1'b1;
        dsr    <= dlm[16:0];
      end

      if ((state == DATA || state == CHECK) && sample) begin
        if (!half_ph) begin
          first_half <= s;
          half_ph    <= 1'b1;
        end else begin
          half_ph <= 1'b0;
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      if (sh_d) word_sr <= {word_sr[13:0], first_half};
      if (word_done) begin
        word_out_q   <= {word_sr, first_half};
        word_count_q <= word_count_q + 1'b1;
        grp_cnt      <= grp_cnt + 1'b1;
      end
      if (chk_done) begin
        bit_cnt <= '0;
        grp_cnt <= '0;
        if (crc_e) crc_err_q <= 1'b1;
      end

      if (go_start) begin
        half_ph      <= 1'b0;
        bit_cnt      <= '0;
        grp_cnt      <= '0;
        word_count_q <= '0;
        crc_err_q    <= 1'b0;
        frame_type_q <= slave_hit;
        exp_cnt      <= slave_hit ? bus.exp_words : 5'd1;
      end
    end
  end

  assign bus.frame_start = frame_start_q;
  assign bus.frame_type  = frame_type_q;
  assign bus.word_out    = word_out_q;
  assign bus.word_valid  = word_valid_q;
  assign bus.word_count  = word_count_q;
  assign bus.frame_over  = frame_over_q;
  assign bus.crc_err     = crc_err_q;
  assign bus.code_err    = code_err_q;

`ifdef MVB_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_run, to_pulse;

  // Armed by a master frame end; any reply edge while idle disarms it.
  always_ff @(posedge clk_24M or negedge rst) begin
    if (!rst) begin
      to_cnt   <= '0;
      to_run   <= 1'b0;
      to_pulse <= 1'b0;
    end else begin
      to_pulse <= 1'b0;
      if (over && !frame_type_q) begin
        to_cnt <= TO_W'(TIMEOUT_CYC);
        to_run <= 1'b1;
      end else if (to_run) begin
        if (state == IDLE && rise) to_run <= 1'b0;
        else if (state == IDLE || state == QUIET) begin
          if (to_cnt <= TO_W'(1)) begin
            to_cnt   <= '0;
            to_run   <= 1'b0;
            to_pulse <= 1'b1;
          end else to_cnt <= to_cnt - 1'b1;
        end
      end
    end
  end

  assign bus.reply_timeout = to_pulse;
`else
  // Watchdog not built; expression is constant 0.
  assign bus.reply_timeout = (TIMEOUT_CYC < 0);
`endif

endmodule

// File: tb/tb_mvb_decode.sv
// Scoreboard bench for mvb_decode: stimulus pushes expected events, a monitor
// pops and compares them whenever the decoder pulses an output.
module tb_mvb_decode;
  import mvb_pkg::*;

  localparam int HC = 8;
  localparam int K_START = 0, K_WORD = 1, K_OVER = 2, K_CERR = 3;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0, n_pass = 0, cyc = 0;
  int   over_t = 0, to_t = 0;
  logic saw_to = 1'b0;
  ev_t  exp_q[$];
  logic [15:0] wbuf[16];

  mvb_decode_if bus();

  mvb_decode #(.HALF_CYC(HC), .TIMEOUT_CYC(100)) dut (
    .clk_24M (clk),
    .rst     (rst_n),
    .bus     (bus)
  );

  always #21 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  function automatic void push(input int k, input logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  task automatic got_ev(input int kind, input logic [31:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL unexpected event kind=%0d: got %h, want none", kind, d);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("event(kind %0d)", e.kind), {kind[3:0], d[27:0]}, {e.kind[3:0], e.data[27:0]});
    end
  endtask

  function automatic logic [31:0] outs();
    return {4'd0, bus.frame_start, bus.frame_type, bus.word_out, bus.word_valid,
            bus.word_count, bus.frame_over, bus.crc_err, bus.code_err, bus.reply_timeout};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.frame_start) got_ev(K_START, {30'd0, bus.crc_err, bus.frame_type});
      if (bus.word_valid)  got_ev(K_WORD, {11'd0, bus.word_count, bus.word_out});
      if (bus.frame_over) begin
        got_ev(K_OVER, {26'd0, bus.crc_err, bus.word_count});
        over_t = cyc;
      end
      if (bus.code_err) got_ev(K_CERR, 32'd0);
      if (bus.reply_timeout) begin
        saw_to = 1'b1;
        to_t   = cyc;
      end
    end
  end

  task automatic half(input logic b);
    bus.line_in = b;
    repeat (HC) @(negedge clk);
  endtask
  task automatic sbit(input logic b);
    half(b);
    half(~b);
  endtask
  task automatic idle(input int n);
    repeat (n) half(1'b0);
  endtask
  task automatic delim(input logic [17:0] p);
    for (int i = 17; i >= 0; i--) half(p[i]);
  endtask
  task automatic sword(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) sbit(w[i]);
  endtask
  task automatic sbyte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) sbit(b[i]);
  endtask

  // Reference check byte: CRC7 (x^7+x^6+x^5+x^2+1, init 0) then even parity.
  function automatic logic [7:0] chk_byte(input int first, input int cnt);
    logic [6:0] c;
    logic       d, fb;
    int         ones;
    c = '0;
    ones = 0;
    for (int w = first; w < first + cnt; w++)
      for (int b = 15; b >= 0; b--) begin
        d = wbuf[w][b];
        ones += int'(d);
        fb = d ^ c[6];
        c = {c[5:0], 1'b0};
        if (fb) c = c ^ 7'b1100101;
      end
    for (int i = 0; i < 7; i++) ones += int'(c[i]);
    return {c, 1'(ones % 2)};
  endfunction

  task automatic send_frame(input bit slave, input int n, input int flip_grp, input logic [7:0] flip);
    int         ng, cnt;
    logic [7:0] cb;
    bit         bad;
    ng  = (n + 3) / 4;
    bad = 1'b0;
    push(K_START, {30'd0, 1'b0, slave});
    for (int w = 0; w < n; w++) push(K_WORD, {11'd0, 5'(w + 1), wbuf[w]});
    delim(slave ? SSD : MSD);
    for (int g = 0; g < ng; g++) begin
      cnt = (n - g * 4 > 4) ? 4 : n - g * 4;
      for (int w = 0; w < cnt; w++) sword(wbuf[g * 4 + w]);
      cb = chk_byte(g * 4, cnt);
      if (g == flip_grp) begin
        cb  = cb ^ flip;
        bad = (flip != 8'h00);
      end
      sbyte(cb);
    end
    push(K_OVER, {26'd0, bad, 5'(n)});
    idle(6);
  endtask

  initial begin
    logic [15:0] w;
    bus.line_in   = 1'b0;
    bus.exp_words = 5'd8;
    repeat (3) @(negedge clk);
    chk("reset outputs", outs(), 32'd0);
    rst_n = 1'b1;
    idle(6);

    wbuf[0] = 16'h1234;
    send_frame(1'b0, 1, -1, 8'h00);

    for (int i = 0; i < 8; i++) wbuf[i] = 16'(i + 1);
    bus.exp_words = 5'd8;
    send_frame(1'b1, 8, -1, 8'h00);
    send_frame(1'b1, 8, 1, 8'h08);

    wbuf[0] = 16'hA5F0;
    wbuf[1] = 16'h0FFF;
    bus.exp_words = 5'd2;
    send_frame(1'b1, 2, -1, 8'h00);

    // Data bit 5 sent as 11
    w = 16'h1234;
    push(K_START, 32'd0);
    push(K_CERR, 32'd0);
    delim(MSD);
    for (int i = 0; i < 5; i++) sbit(w[15 - i]);
    half(1'b1);
    half(1'b1);
    idle(8);
    wbuf[0] = 16'hBEEF;
    send_frame(1'b0, 1, -1, 8'h00);

    // Stray half-bit after a good check byte
    wbuf[0] = 16'h1234;
    push(K_START, 32'd0);
    push(K_WORD, {11'd0, 5'd1, 16'h1234});
    push(K_CERR, 32'd0);
    delim(MSD);
    sword(16'h1234);
    sbyte(chk_byte(0, 1));
    half(1'b1);
    idle(8);

    push(K_CERR, 32'd0);
    delim(18'b10_11_00_01_11_00_01_01_10);
    idle(8);

    bus.exp_words = 5'd3;
    push(K_CERR, 32'd0);
    delim(SSD);
    idle(8);

    // Reset in the middle of a word
    push(K_START, 32'd0);
    delim(MSD);
    for (int i = 0; i < 6; i++) sbit(w[15 - i]);
    bus.line_in = 1'b0;
    rst_n = 1'b0;
    #1 chk("outputs at reset assert", outs(), 32'd0);
    repeat (3) @(negedge clk);
    chk("outputs during reset", outs(), 32'd0);
    rst_n = 1'b1;
    idle(8);
    wbuf[0] = 16'h8001;
    send_frame(1'b0, 1, -1, 8'h00);

`ifdef MVB_RX_TIMEOUT_EN
    wbuf[0] = 16'h00FF;
    saw_to  = 1'b0;
    send_frame(1'b0, 1, -1, 8'h00);
    idle(16);
    chk("timeout fired", {31'd0, saw_to}, 32'd1);
    chk("timeout delay", {31'd0, (to_t - over_t >= 95 && to_t - over_t <= 110)}, 32'd1);
    send_frame(1'b0, 1, -1, 8'h00);
    for (int i = 0; i < 200 && cyc - over_t < 50; i++) @(negedge clk);
    saw_to = 1'b0;
    wbuf[0] = 16'h5A5A;
    bus.exp_words = 5'd1;
    send_frame(1'b1, 1, -1, 8'h00);
    idle(20);
    chk("no timeout after reply", {31'd0, saw_to}, 32'd0);
`endif

    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
    chk("pending events", exp_q.size(), 32'd0);
`ifndef MVB_RX_TIMEOUT_EN
    chk("reply_timeout quiet", {31'd0, saw_to}, 32'd0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
